// File: rtl/saturn_serial_arbiter_pkg.sv
// saturn_serial_arbiter_pkg: shared FSM encoding and width helpers for the serial arbiter
package saturn_serial_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_TX = 2'd2,
    SEND    = 2'd3
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/saturn_rr_picker.sv
// saturn_rr_picker: round-robin first-set-bit search starting just above the pointer, with wrap
module saturn_rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt,
  output logic         any
);

  // Scan from farthest to nearest so the closest requester after ptr wins
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt = W'((int'(ptr) + i) % N);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/saturn_serial_arbiter.sv
// saturn_serial_arbiter: round-robin, message-locked sharing of one serial transmitter
module saturn_serial_arbiter
  import saturn_serial_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int REQ_ID_W     = 2,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [NUM_REQ*8-1:0]  i_req_char,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [NUM_REQ-1:0]    i_req_last,
  output logic [NUM_REQ-1:0]    o_req_ack,
  output logic [7:0]            o_char_to_send,
  output logic                  o_char_valid,
  input  logic                  i_serial_busy,
  output logic [REQ_ID_W-1:0]   o_grant_id,
  output logic                  o_locked,
  output logic                  o_timeout
);

  localparam int CNT_W = clog2_min1(LOCK_TIMEOUT);

  state_t              state, state_nx;
  logic [REQ_ID_W-1:0] ptr, ptr_nx, grant, grant_nx, pick;
  logic                any;
  logic                locked, locked_nx, timeout_q, timeout_nx;
  logic                cv, cv_nx, last_q, last_nx;
  logic [7:0]          ch, ch_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                ack_now;

  saturn_rr_picker #(.N(NUM_REQ), .W(REQ_ID_W)) u_pick (
    .req (i_req_valid),
    .ptr (ptr),
    .gnt (pick),
    .any (any)
  );

  assign ack_now        = (state == LOAD) && i_req_valid[grant];
  assign o_req_ack      = ack_now ? (NUM_REQ'(1) << grant) : '0;
  assign o_char_to_send = ch;
  assign o_char_valid   = cv;
  assign o_grant_id     = grant;
  assign o_locked       = locked;
  assign o_timeout      = timeout_q;

  // Next-state: grant in IDLE, capture in LOAD, wait for the shifter to idle, pulse valid in SEND
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    grant_nx   = grant;
    locked_nx  = locked;
    timeout_nx = 1'b0;
    cv_nx      = 1'b0;
    last_nx    = last_q;
    ch_nx      = ch;
    cnt_nx     = cnt;
    case (state)
      IDLE: begin
        if (any) begin
          grant_nx  = pick;
          ptr_nx    = pick;
          locked_nx = 1'b1;
          cnt_nx    = '0;
          state_nx  = LOAD;
        end
      end
      LOAD: begin
        if (ack_now) begin
          ch_nx    = i_req_char[{grant, 3'b000} +: 8];
          last_nx  = i_req_last[grant];
          cnt_nx   = '0;
          state_nx = WAIT_TX;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          timeout_nx = 1'b1;
          locked_nx  = 1'b0;
          cnt_nx     = '0;
          state_nx   = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT_TX: begin
        if (!i_serial_busy) begin
          cv_nx    = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        locked_nx = !last_q;
        state_nx  = last_q ? IDLE : LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; pointer resets to the top so requester 0 wins first
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      ptr       <= REQ_ID_W'(NUM_REQ - 1);
      grant     <= '0;
      locked    <= 1'b0;
      timeout_q <= 1'b0;
      cv        <= 1'b0;
      last_q    <= 1'b0;
      ch        <= 8'h00;
      cnt       <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      grant     <= grant_nx;
      locked    <= locked_nx;
      timeout_q <= timeout_nx;
      cv        <= cv_nx;
      last_q    <= last_nx;
      ch        <= ch_nx;
      cnt       <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_saturn_serial_arbiter.sv
// tb_saturn_serial_arbiter: directed checks of arbitration, locking, handshake, timeout and reset
module tb_saturn_serial_arbiter;

  localparam int NR = 4;
  localparam int LT = 16;

  logic            i_clk = 1'b0;
  logic            i_reset_n = 1'b0;
  logic [NR*8-1:0] i_req_char;
  logic [NR-1:0]   i_req_valid, i_req_last, o_req_ack;
  logic [7:0]      o_char_to_send;
  logic            o_char_valid, i_serial_busy;
  logic [1:0]      o_grant_id;
  logic            o_locked, o_timeout;

  int   tx_cnt = 0;
  int   tx_len = 10;
  logic busy_force = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [8:0] q [NR][$];
  int   ack_id [64];
  int   ack_k [64];
  int   cv_ch [64];
  int   cv_k [64];
  int   n_ack, n_cv, n_to, to_k, to_locked, acked_busy, emit_fast;
  logic lk [0:255];
  logic b1, b2, prev_locked;
  logic [1:0] prev_grant;

  saturn_serial_arbiter #(.NUM_REQ(NR), .REQ_ID_W(2), .LOCK_TIMEOUT(LT)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_req_char     (i_req_char),
    .i_req_valid    (i_req_valid),
    .i_req_last     (i_req_last),
    .o_req_ack      (o_req_ack),
    .o_char_to_send (o_char_to_send),
    .o_char_valid   (o_char_valid),
    .i_serial_busy  (i_serial_busy),
    .o_grant_id     (o_grant_id),
    .o_locked       (o_locked),
    .o_timeout      (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // Transmitter model: busy for tx_len cycles starting the cycle after a valid pulse
  assign i_serial_busy = (tx_cnt != 0) | busy_force;
  always @(posedge i_clk) tx_cnt <= o_char_valid ? tx_len : ((tx_cnt != 0) ? tx_cnt - 1 : 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_char_valid", o_char_valid, 0);
    chk("rst_char", o_char_to_send, 8'h00);
    chk("rst_ack", o_req_ack, 0);
    chk("rst_locked", o_locked, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_grant", o_grant_id, 0);
  endtask

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      i_req_valid[r]      = q[r].size() != 0;
      i_req_char[r*8 +: 8] = (q[r].size() != 0) ? q[r][0][7:0] : 8'h00;
      i_req_last[r]       = (q[r].size() != 0) && q[r][0][8];
    end
  endtask

  task automatic clear_logs();
    n_ack = 0; n_cv = 0; n_to = 0; to_k = -1; to_locked = -1;
    acked_busy = 0; emit_fast = 0; b1 = 1'b0; b2 = 1'b0; prev_locked = 1'b0; prev_grant = 2'd0;
    for (int i = 0; i < 64; i++) begin
      ack_id[i] = -1; ack_k[i] = -1; cv_ch[i] = -1; cv_k[i] = -1;
    end
    for (int i = 0; i < 256; i++) lk[i] = 1'b0;
  endtask

  task automatic sample(input int k);
    if (o_req_ack != 0) begin
      chk("ack_onehot", 32'($onehot(o_req_ack)), 1);
      if (n_ack < 64) begin
        for (int r = 0; r < NR; r++) if (o_req_ack[r]) ack_id[n_ack] = r;
        ack_k[n_ack] = k;
        n_ack++;
      end
      if (i_serial_busy) acked_busy++;
    end
    if (o_char_valid) begin
      chk("valid_while_busy", i_serial_busy, 0);
      if (n_cv < 64) begin
        cv_ch[n_cv] = o_char_to_send;
        cv_k[n_cv] = k;
        n_cv++;
      end
      if (b2 && !b1) emit_fast++;
    end
    if (o_timeout) begin
      to_k = k;
      to_locked = o_locked;
      n_to++;
    end
    if (o_locked && prev_locked) chk("grant_stable", o_grant_id, prev_grant);
    lk[k] = o_locked;
    prev_locked = o_locked;
    prev_grant = o_grant_id;
    b2 = b1;
    b1 = i_serial_busy;
  endtask

  // Cycle k=0 is the cycle in which run() is entered; acked characters are withdrawn next cycle
  task automatic run(input int n);
    logic [NR-1:0] a;
    clear_logs();
    for (int k = 0; k < n; k++) begin
      drive();
      @(negedge i_clk);
      a = o_req_ack;
      sample(k);
      @(posedge i_clk);
      #1;
      for (int r = 0; r < NR; r++) if (a[r]) void'(q[r].pop_front());
    end
    drive();
  endtask

  task automatic chk_drained(input string tag);
    chk(tag, q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_req_valid = '0;
    i_req_char  = '0;
    i_req_last  = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_reset_values();
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;

    q[0].push_back({1'b1, 8'h41});
    run(16);
    chk("single_n_ack", n_ack, 1);
    chk("single_ack_k", ack_k[0], 1);
    chk("single_ack_id", ack_id[0], 0);
    chk("single_n_cv", n_cv, 1);
    chk("single_cv_k", cv_k[0], 3);
    chk("single_cv_char", cv_ch[0], 8'h41);
    chk("single_locked_in_send", lk[3], 1);
    chk("single_unlocked_after", lk[4], 0);
    chk_drained("single_drained");

    q[1].push_back({1'b0, 8'h4F});
    q[1].push_back({1'b0, 8'h4B});
    q[1].push_back({1'b1, 8'h0A});
    q[2].push_back({1'b1, 8'h5A});
    run(50);
    chk("lock_n_ack", n_ack, 4);
    chk("lock_ack0", ack_id[0], 1);
    chk("lock_ack1", ack_id[1], 1);
    chk("lock_ack2", ack_id[2], 1);
    chk("lock_ack3", ack_id[3], 2);
    chk("lock_ch0", cv_ch[0], 8'h4F);
    chk("lock_ch1", cv_ch[1], 8'h4B);
    chk("lock_ch2", cv_ch[2], 8'h0A);
    chk("lock_ch3", cv_ch[3], 8'h5A);
    chk("lock_cv_k0", cv_k[0], 3);
    chk("lock_cv_k1", cv_k[1], 15);
    chk("lock_cv_k2", cv_k[2], 27);
    chk("lock_cv_k3", cv_k[3], 39);
    chk("busy_acked_while_busy", acked_busy, 3);
    chk("busy_emit_after_fall", emit_fast, 3);
    chk_drained("lock_drained");

    i_reset_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    q[0].push_back({1'b1, 8'h61});
    q[1].push_back({1'b1, 8'h62});
    q[3].push_back({1'b1, 8'h63});
    q[0].push_back({1'b1, 8'h64});
    q[1].push_back({1'b1, 8'h65});
    q[3].push_back({1'b1, 8'h66});
    run(76);
    chk("rr_n_ack", n_ack, 6);
    chk("rr_ack0", ack_id[0], 0);
    chk("rr_ack1", ack_id[1], 1);
    chk("rr_ack2", ack_id[2], 3);
    chk("rr_ack3", ack_id[3], 0);
    chk("rr_ack4", ack_id[4], 1);
    chk("rr_ack5", ack_id[5], 3);
    chk("rr_n_cv", n_cv, 6);
    chk("rr_ch2", cv_ch[2], 8'h63);
    chk("rr_ch5", cv_ch[5], 8'h66);
    chk("rr_cv_k5", cv_k[5], 63);
    chk_drained("rr_drained");

    q[0].push_back({1'b0, 8'h31});
    q[2].push_back({1'b1, 8'h42});
    run(40);
    chk("to_n_pulse", n_to, 1);
    chk("to_cycle", to_k, 20);
    chk("to_unlocked", to_locked, 0);
    chk("to_locked_before", lk[19], 1);
    chk("to_n_ack", n_ack, 2);
    chk("to_ack0", ack_id[0], 0);
    chk("to_ack1", ack_id[1], 2);
    chk("to_ack1_k", ack_k[1], 21);
    chk("to_ch0", cv_ch[0], 8'h31);
    chk("to_ch1", cv_ch[1], 8'h42);
    chk_drained("to_drained");

    busy_force = 1'b1;
    q[0].push_back({1'b1, 8'h52});
    run(4);
    chk("rst_pre_char", o_char_to_send, 8'h52);
    chk("rst_pre_locked", o_locked, 1);
    chk("rst_pre_no_cv", n_cv, 0);
    i_reset_n = 1'b0;
    #1;
    chk_reset_values();
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    q[1].push_back({1'b1, 8'h53});
    run(8);
    chk("rst_hold_n_cv", n_cv, 0);
    chk("rst_hold_n_ack", n_ack, 1);
    chk("rst_hold_ack_id", ack_id[0], 1);
    busy_force = 1'b0;
    run(14);
    chk("rst_rel_n_cv", n_cv, 1);
    chk("rst_rel_cv_k", cv_k[0], 1);
    chk("rst_rel_char", cv_ch[0], 8'h53);
    chk_drained("rst_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
